booth_multiplier: RTL
=====================

// Module: booth_multiplier
// PURPOSE
//  Multi-cycle signed 32x32 multiplier for the ALU's mult/div path. Radix-2 Booth recoding:
//  each iteration conditionally adds or subtracts the multiplicand into the upper product
//  half, then arithmetic-right-shifts the whole product register by one. Consumes operands
//  from the decode/execute latch; drives the low 32 product bits and a ready/exception pair
//  to writeback.
// PARAMETERS
//  WIDTH  32  operand and result width; iteration count = WIDTH
// PORTS
//  clock            in   1      system clock; all state updates on rising edge
//  reset            in   1      asynchronous, active-high; clears all state
//  ctrl_MULT        in   1      start pulse; latches both operands this cycle
//  data_operandA    in   WIDTH  multiplicand (signed)
//  data_operandB    in   WIDTH  multiplier (signed)
//  data_result      out  WIDTH  low WIDTH bits of the signed product
//  data_resultRDY   out  1      one-cycle pulse: result valid
//  data_exception   out  1      signed overflow flag; valid while data_resultRDY=1
// BEHAVIOUR
//  Clocking: single clock domain on clock; reset is asynchronous and active-high.
//  Reset: state=IDLE, counter=0, product reg=0, data_result=0, data_resultRDY=0,
//    data_exception=0. Asserting reset mid-operation aborts the operation; no RDY pulse follows.
//  Datapath: M = operandA latched (WIDTH bits); P = {hi[WIDTH], lo[WIDTH-1:0], q_m1}, total
//    2*WIDTH+2 bits. The extra hi bit absorbs add/sub carry.
//  Start: on ctrl_MULT, P <= {0, operandB, 1'b0} and M <= operandA; counter <= 0; state <= RUN.
//  RUN, one step per cycle: {lo[0],q_m1}: 00/11 no-op; 01 hi += sext(M); 10 hi -= sext(M);
//    then P <= P >>> 1 (arithmetic, hi MSB replicated); counter++.
//  After WIDTH steps, state <= DONE. Latency: start at edge 0 -> RDY high during cycle WIDTH+1
//    (cycle 33 at default WIDTH).
//  DONE: data_resultRDY=1 for exactly one cycle, then IDLE.
//  Outputs: data_result = lo, registered; holds its last value until the next start.
//  Restart: ctrl_MULT during RUN or DONE discards the current operation and relatches the
//    operands. The suppressed RDY pulse is not emitted for the aborted operation.
//  Operand changes while not starting: ignored.
//  Corner cases: WIDTH-bit wrap of -2^31 * -1 gives 0x80000000; 0 operands run the full
//    latency with no early exit.
//  States: IDLE -ctrl_MULT-> RUN -counter==WIDTH-1-> DONE -> IDLE.
//    reset from any state -> IDLE.
// CONFIGURATION
//  MULT_OVERFLOW_EN defined: data_exception=1 in DONE when hi[WIDTH:0] bits are not all equal
//    to lo[WIDTH-1], i.e. the true product does not fit WIDTH signed bits.
//  MULT_OVERFLOW_EN undefined: data_exception tied to 0 and the check logic is absent.
// STRUCTURE
//  Shared include mult_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and
//    MULT_CNT_W = clog2(WIDTH).
//  Sub-module booth_step (combinational): inputs P and M; output next P, covering recode,
//    add/sub and the 1-bit arithmetic right shift.
//  Top level holds only the FSM, counter and registers.
// TESTING
//  1. 7 * 6, start at cycle 0 -> data_result=42, RDY high in cycle 33 only, exception=0.
//  2. -3 * 5 -> 0xFFFFFFF1; 0x80000000 * 1 -> 0x80000000, exception=0.
//  3. 0x7FFFFFFF * 2 -> 0xFFFFFFFE, exception=1 (macro on) / 0 (macro off).
//  4. 0x80000000 * 0xFFFFFFFF -> 0x80000000, exception=1 with macro; 0 * 0 -> 0,
//     RDY at cycle 33.
//  5. Start 9*9; at cycle 10 restart with 4*-4 -> single RDY, 33 cycles after the restart,
//     result 0xFFFFFFF0.
//  6. Assert reset at cycle 15 of a run -> outputs 0 asynchronously, no RDY;
//     a new start completes correctly.

Source files
------------

// File: rtl/booth_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// booth_multiplier_pkg
//   Shared definitions for the radix-2 Booth multiplier:
//     - state_e     : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//     - DEFAULT_WIDTH : default operand/result width
//     - cnt_width() : width of the iteration counter for a given WIDTH
// ---------------------------------------------------------------------------
package booth_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/booth_multiplier_step.sv
// ---------------------------------------------------------------------------
// booth_step
//   One radix-2 Booth iteration, purely combinational.
//   Product register layout: P = {hi[WIDTH:0], lo[WIDTH-1:0], q_m1}.
//   Recode on {lo[0], q_m1}: 01 -> hi += M, 10 -> hi -= M, else no-op;
//   then the whole register is arithmetic-shifted right by one.
// Ports:
//   p_i  [2*WIDTH+1:0]  current product register
//   m_i  [WIDTH-1:0]    multiplicand (signed)
//   p_o  [2*WIDTH+1:0]  product register after this step
// ---------------------------------------------------------------------------
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH+1:0] p_o
);

  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   hi_sum;

  assign hi    = p_i[2*WIDTH+1:WIDTH+1];
  assign lo    = p_i[WIDTH:1];
  assign m_ext = {m_i[WIDTH-1], m_i};

  always_comb begin
    // NOTE: default first so every path assigns hi_sum and no latch is inferred.
    hi_sum = hi;
    unique case ({p_i[1], p_i[0]})
      2'b01:   hi_sum = hi + m_ext;
      2'b10:   hi_sum = hi - m_ext;
      default: hi_sum = hi;
    endcase
  end

  // Arithmetic shift: hi MSB replicated, old q_m1 dropped, lo[0] becomes q_m1.
  assign p_o = {hi_sum[WIDTH], hi_sum, lo};

endmodule

// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
//   Multi-cycle signed WIDTH x WIDTH multiplier (radix-2 Booth), one recode
//   step per clock. A start pulse latches both operands; WIDTH steps later
//   the FSM enters DONE and the following edge registers the low WIDTH
//   product bits and raises data_resultRDY for one cycle.
//   Start at edge 0 -> data_resultRDY high in cycle WIDTH+1.
//   A start while RUN or DONE aborts the current operation (no RDY for it).
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-high
//   ctrl_MULT       in   start pulse, latches operands
//   data_operandA   in   [WIDTH-1:0] multiplicand (signed)
//   data_operandB   in   [WIDTH-1:0] multiplier (signed)
//   data_result     out  [WIDTH-1:0] low product bits, registered, held
//   data_resultRDY  out  one-cycle result-valid pulse
//   data_exception  out  signed overflow flag, valid with data_resultRDY
// Configuration:
//   MULT_OVERFLOW_EN  defined   -> overflow check drives data_exception
//                     undefined -> data_exception tied to 0
// ---------------------------------------------------------------------------
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int P_W   = 2 * WIDTH + 2;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [P_W-1:0]   p_q;
  logic [P_W-1:0]   p_d;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] result_q;
  logic             rdy_q;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p_i (p_q),
    .m_i (m_q),
    .p_o (p_d)
  );

`ifdef MULT_OVERFLOW_EN
  logic exc_q;
  logic ovf;

  // Product fits WIDTH signed bits only if hi is a pure sign extension of lo.
  assign ovf = (p_q[P_W-1:WIDTH+1] != {(WIDTH+1){p_q[WIDTH]}});
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
`ifdef MULT_OVERFLOW_EN
      exc_q    <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b0;
`ifdef MULT_OVERFLOW_EN
      exc_q <= 1'b0;
`endif
      if (ctrl_MULT) begin
        // Start (or restart): any in-flight operation is discarded.
        p_q     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
        m_q     <= data_operandA;
        cnt_q   <= '0;
        state_q <= ST_RUN;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            p_q   <= p_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            result_q <= p_q[WIDTH:1];
            rdy_q    <= 1'b1;
`ifdef MULT_OVERFLOW_EN
            exc_q    <= ovf;
`endif
            state_q  <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
`ifdef MULT_OVERFLOW_EN
  assign data_exception = exc_q;
`else
  assign data_exception = 1'b0;
`endif

endmodule
